// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes SPI command frames from spi_buffer and issues one memory bus access per frame
//   sys_clk, reset_n      : clock, asynchronous active-low reset
//   spi_cs_n              : synchronized chip select, low while a frame is active
//   rx_bytes, rx_count    : received bytes (rx[0] in [7:0]) and how many are valid
//   bus_req/we/addr/wr_data, bus_rd_data, bus_ack : memory bus handshake
//   rd_data, rd_valid     : last read byte and its one-cycle update pulse
//   cmd_done, timeout_err : completion pulse and sticky ack-timeout flag
module spi_cmd_ctrl #(
  parameter int ADDR_WIDTH  = 17,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  spi_cs_n,
  input  logic [31:0]           rx_bytes,
  input  logic [2:0]            rx_count,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wr_data,
  input  logic [7:0]            bus_rd_data,
  input  logic                  bus_ack,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  cmd_done,
  output logic                  timeout_err
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, REQ, DONE} state_t;
  state_t                  state;
  logic                    cs_prev;
  logic [2:0]              rx_prev;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [TW-1:0]           to_cnt;
  logic [1:0]              op;
  logic [2:0]              need;
  logic                    ready;
  logic [16:0]             abs17;
  logic [ADDR_WIDTH-1:0]   abs_addr;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic                    unused_cmd_bits;
  always_comb begin
    op              = rx_bytes[7:6];
    need            = op == 2'b00 ? 3'd3 : op == 2'b01 ? 3'd4 : op == 2'b10 ? 3'd1 : 3'd2;
    ready           = rx_count != 3'd0 && rx_count >= need;
    abs17           = {rx_bytes[0], rx_bytes[15:8], rx_bytes[23:16]};
    abs_addr        = ADDR_WIDTH'(abs17);
    next_addr       = addr_reg + ADDR_WIDTH'(1);
    unused_cmd_bits = ^rx_bytes[5:1];
  end
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cs_prev     <= 1'b1;
      rx_prev     <= '0;
      addr_reg    <= '0;
      to_cnt      <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      cmd_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cs_prev  <= spi_cs_n;
      rx_prev  <= rx_count;
      cmd_done <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (cs_prev && !spi_cs_n) begin
          timeout_err <= 1'b0;
          state       <= WAIT;
        end
        // a shrinking rx_count means spi_buffer was reset under us: drop the frame
        WAIT: if (spi_cs_n || rx_count < rx_prev) begin
          state <= IDLE;
        end else if (ready) begin
          bus_req     <= 1'b1;
          bus_we      <= op[0];
          bus_addr    <= op[1] ? next_addr : abs_addr;
          bus_wr_data <= op[1] ? rx_bytes[15:8] : rx_bytes[31:24];
          to_cnt      <= '0;
          state       <= REQ;
        end
        // ack is tested first so it wins over a coincident terminal count
        REQ: if (bus_ack) begin
          bus_req  <= 1'b0;
          addr_reg <= bus_addr;
          cmd_done <= 1'b1;
          rd_data  <= bus_we ? rd_data : bus_rd_data;
          rd_valid <= !bus_we;
          state    <= spi_cs_n ? IDLE : DONE;
        end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
          bus_req     <= 1'b0;
          timeout_err <= 1'b1;
          state       <= spi_cs_n ? IDLE : DONE;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
        DONE: if (spi_cs_n) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed and randomized frames checked against a frame-level model
module tb_spi_cmd_ctrl;
  localparam int AW = 17;
  localparam int TO = 8;
  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic [31:0]   rx_bytes = '0;
  logic [2:0]    rx_count = '0;
  logic          bus_req, bus_we, bus_ack, rd_valid, cmd_done, timeout_err;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wr_data, bus_rd_data, rd_data;
  int            checks = 0, failures = 0;
  int            ack_dly = 0;
  logic [7:0]    rd_val = '0;
  int            req_cnt = 0, done_cnt = 0, rdv_cnt = 0, req_len = 0;
  logic          req_prev = 1'b0, ack_prev = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic          cap_we = 1'b0;
  logic [7:0]    cap_data = '0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_rd = '0;
  always #5 sys_clk = ~sys_clk;
  spi_cmd_ctrl #(.ADDR_WIDTH(AW), .ACK_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .spi_cs_n(spi_cs_n),
    .rx_bytes(rx_bytes), .rx_count(rx_count),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_ack(bus_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .cmd_done(cmd_done), .timeout_err(timeout_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask
  function automatic int need_of(input logic [1:0] op);
    return op == 2'd0 ? 3 : op == 2'd1 ? 4 : op == 2'd2 ? 1 : 2;
  endfunction
  // bus slave: acks after ack_dly cycles of bus_req (never when negative)
  initial begin
    int w;
    logic sent;
    w = 0;
    sent = 1'b0;
    bus_ack = 1'b0;
    bus_rd_data = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      bus_ack = 1'b0;
      bus_rd_data = 8'($urandom);
      if (bus_req) begin
        if (ack_dly >= 0 && w == ack_dly && !sent) begin
          bus_ack = 1'b1;
          bus_rd_data = rd_val;
          sent = 1'b1;
        end
        w++;
      end else begin
        w = 0;
        sent = 1'b0;
      end
    end
  end
  // cycle monitor: handshake timing, stability and pulse counting
  always @(negedge sys_clk) begin
    if (!reset_n) begin
      req_prev = 1'b0;
      ack_prev = 1'b0;
    end else begin
      if (cmd_done) done_cnt++;
      if (rd_valid) rdv_cnt++;
      if (ack_prev) begin
        chk("req_drop_after_ack", 32'(bus_req), 0);
        chk("cmd_done_after_ack", 32'(cmd_done), 1);
        chk("rd_valid_on_read", 32'(rd_valid), 32'(!cap_we));
      end else begin
        chk("no_spurious_done", 32'(cmd_done), 0);
        chk("no_spurious_rd_valid", 32'(rd_valid), 0);
      end
      if (bus_req && !req_prev) begin
        req_cnt++;
        cap_addr = bus_addr;
        cap_we = bus_we;
        cap_data = bus_wr_data;
        req_len = 1;
      end else if (bus_req) begin
        req_len++;
        chk("addr_stable", 32'(bus_addr), 32'(cap_addr));
        chk("we_stable", 32'(bus_we), 32'(cap_we));
        chk("wr_data_stable", 32'(bus_wr_data), 32'(cap_data));
      end else if (req_prev && !ack_prev) begin
        chk("timeout_req_len", req_len, TO);
      end
      ack_prev = bus_req && bus_ack;
      req_prev = bus_req;
    end
  end
  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input int nsend, input int dly, input logic [7:0] rv);
    logic [7:0]    b[4];
    int            n, r0, d0, v0;
    logic          go, rd, ack;
    logic [AW-1:0] ea;
    logic [7:0]    ed;
    b = '{b0, b1, b2, b3};
    n = need_of(b0[7:6]);
    go = nsend >= n;
    rd = !b0[6];
    ack = dly >= 0 && dly < TO;
    ea = b0[7] ? m_addr + 1'b1 : {b0[0], b1, b2};
    ed = b0[7] ? b1 : b3;
    r0 = req_cnt;
    d0 = done_cnt;
    v0 = rdv_cnt;
    ack_dly = dly;
    rd_val = rv;
    spi_cs_n = 1'b0;
    rx_count = '0;
    rx_bytes = '0;
    tick(2);
    for (int i = 0; i < nsend; i++) begin
      rx_bytes[8*i +: 8] = b[i];
      rx_count = 3'(i + 1);
      if (i + 1 <= n) chk("no_req_before_n", 32'(bus_req), 0);
      tick(1);
      if (i + 1 == n) chk("req_latency", 32'(bus_req), 1);
      tick(1);
    end
    tick(TO + 8);
    spi_cs_n = 1'b1;
    rx_count = '0;
    tick(2);
    chk("req_count", req_cnt - r0, 32'(go));
    if (go) begin
      chk("bus_addr", 32'(cap_addr), 32'(ea));
      chk("bus_we", 32'(cap_we), 32'(!rd));
      if (!rd) chk("bus_wr_data", 32'(cap_data), 32'(ed));
      chk("done_count", done_cnt - d0, 32'(ack));
      chk("rd_valid_count", rdv_cnt - v0, 32'(ack && rd));
      if (ack) begin
        m_addr = ea;
        if (rd) m_rd = rv;
      end
    end else begin
      chk("done_count_abort", done_cnt - d0, 0);
    end
    chk("timeout_err", 32'(timeout_err), 32'(go && !ack));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
  endtask
  task automatic check_all_zero(input string tag);
    chk({tag, "_bus_req"}, 32'(bus_req), 0);
    chk({tag, "_bus_we"}, 32'(bus_we), 0);
    chk({tag, "_bus_addr"}, 32'(bus_addr), 0);
    chk({tag, "_bus_wr_data"}, 32'(bus_wr_data), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_cmd_done"}, 32'(cmd_done), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask
  initial begin
    int r0, d0;
    logic [1:0] op;
    #1;
    check_all_zero("reset");
    tick(3);
    reset_n = 1'b1;
    tick(2);
    frame(8'h41, 8'h12, 8'h34, 8'h5A, 4, 3, 8'h00);
    frame(8'h00, 8'h20, 8'h00, 8'h00, 3, 2, 8'hC3);
    frame(8'h80, 8'h00, 8'h00, 8'h00, 1, 1, 8'h3C);
    frame(8'h41, 8'hFF, 8'hFF, 8'h11, 4, 0, 8'h00);
    frame(8'hC0, 8'h77, 8'hAA, 8'hBB, 4, 2, 8'h00);
    frame(8'h40, 8'h12, 8'h00, 8'h00, 2, 0, 8'h00);
    frame(8'h80, 8'h00, 8'h00, 8'h00, 1, 0, 8'h55);
    frame(8'h80, 8'h00, 8'h00, 8'h00, 1, TO - 1, 8'h66);
    frame(8'h01, 8'h01, 8'h02, 8'h00, 3, -1, 8'h00);
    spi_cs_n = 1'b0;
    tick(2);
    chk("timeout_err_cleared", 32'(timeout_err), 0);
    spi_cs_n = 1'b1;
    tick(2);
    r0 = req_cnt;
    spi_cs_n = 1'b0;
    tick(2);
    rx_bytes = 32'h5A341241;
    rx_count = 3'd1;
    tick(2);
    rx_count = 3'd0;
    tick(2);
    rx_count = 3'd4;
    tick(4);
    chk("shrink_abort_req", req_cnt - r0, 0);
    spi_cs_n = 1'b1;
    rx_count = '0;
    tick(2);
    r0 = req_cnt;
    d0 = done_cnt;
    ack_dly = 4;
    rd_val = 8'hA5;
    spi_cs_n = 1'b0;
    tick(2);
    rx_bytes = 32'h00000080;
    rx_count = 3'd1;
    tick(2);
    spi_cs_n = 1'b1;
    rx_count = '0;
    tick(1);
    spi_cs_n = 1'b0;
    rx_count = 3'd1;
    tick(12);
    chk("cs_in_req_one_req", req_cnt - r0, 1);
    chk("cs_in_req_done", done_cnt - d0, 1);
    chk("cs_in_req_addr", 32'(cap_addr), 32'(AW'(m_addr + 1'b1)));
    m_addr = m_addr + 1'b1;
    m_rd = 8'hA5;
    spi_cs_n = 1'b1;
    rx_count = '0;
    tick(2);
    frame(8'hC1, 8'h3E, 8'h00, 8'h00, 2, 1, 8'h00);
    ack_dly = -1;
    spi_cs_n = 1'b0;
    tick(2);
    rx_bytes = 32'h00000080;
    rx_count = 3'd1;
    tick(3);
    chk("req_before_async_reset", 32'(bus_req), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick(2);
    reset_n = 1'b1;
    spi_cs_n = 1'b1;
    rx_count = '0;
    tick(2);
    m_addr = '0;
    m_rd = '0;
    frame(8'h80, 8'h00, 8'h00, 8'h00, 1, 1, 8'h99);
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      frame({op, 5'($urandom), 1'($urandom)}, 8'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(1, 4), ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TO - 1),
            8'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command sequencer between spi_buffer and the system memory bus.
- Watches the SPI receive buffer as bytes arrive and decodes the command byte.
- Once the command's required byte count is present, issues one bus read or write and returns the read data for the next SPI transmit byte.
- Keeps a persistent address register, so "_NEXT" commands stream through memory without resending the address.

Parameters:
- ADDR_WIDTH, 17: bus address width. Fixed usage: A16 comes from cmd[0], A15:0 from rx[1]:rx[2].
- ACK_TIMEOUT, 255: maximum sys_clk cycles to wait for bus_ack before aborting.

Ports:
- sys_clk  in  1: system clock.
- reset_n  in  1: asynchronous active-low reset.
- spi_cs_n  in  1: SPI chip select, already synchronized to sys_clk. Low means a frame is active.
- rx_bytes  in  32: spi_buffer contents. rx[0]=[7:0], rx[1]=[15:8], rx[2]=[23:16], rx[3]=[31:24].
- rx_count  in  3: number of valid bytes in rx_bytes for the current frame (0..4).
- bus_req  out  1: bus request, held high until bus_ack or timeout.
- bus_we  out  1: 1=write, 0=read. Valid while bus_req is high.
- bus_addr  out  ADDR_WIDTH: bus address. Valid while bus_req is high.
- bus_wr_data  out  8: write data. Valid while bus_req and bus_we are high.
- bus_rd_data  in  8: read data. Sampled on the cycle bus_ack is high.
- bus_ack  in  1: one-cycle completion pulse from the bus.
- rd_data  out  8: last read result. Held until the next read completes.
- rd_valid  out  1: one-cycle pulse when rd_data updates.
- cmd_done  out  1: one-cycle pulse per completed bus access.
- timeout_err  out  1: sticky error flag; cleared at the start of the next frame.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State IDLE.
  - Outputs: bus_req=0, bus_we=0, bus_addr=0, bus_wr_data=0, rd_data=0, rd_valid=0, cmd_done=0, timeout_err=0.
  - Address register=0; timeout counter=0.
- Opcode = cmd[7:6]; required byte count N:
  - 00 READ, N=3: addr={cmd[0],rx[1],rx[2]}.
  - 01 WRITE, N=4: addr={cmd[0],rx[1],rx[2]}, data=rx[3].
  - 10 READ_NEXT, N=1: addr=addr_reg+1.
  - 11 WRITE_NEXT, N=2: addr=addr_reg+1, data=rx[1].
  - cmd[5:1] ignored.
- State IDLE:
  - On the spi_cs_n falling edge (1->0 between consecutive cycles): clear timeout_err, go to WAIT.
- State WAIT:
  - When rx_count>=1, decode the opcode from rx[0] combinationally.
  - When rx_count>=N: latch addr/data/we into the bus outputs, assert bus_req on the next edge, go to REQ.
  - Latency: 1 cycle from rx_count reaching N to bus_req high.
- State REQ:
  - bus_req, bus_we, bus_addr and bus_wr_data are held stable.
  - On bus_ack:
    - Drop bus_req the following cycle.
    - addr_reg <= bus_addr.
    - Pulse cmd_done.
    - On a read: rd_data <= bus_rd_data and pulse rd_valid in the same cycle as cmd_done.
    - Go to DONE.
  - Timeout counter runs only in REQ. When it reaches ACK_TIMEOUT with no ack:
    - Drop bus_req, set timeout_err.
    - No cmd_done; addr_reg unchanged.
    - Go to DONE.
- State DONE:
  - Ignore further rx_count growth; one command per frame.
  - Go to IDLE when spi_cs_n=1.
- spi_cs_n rising while in WAIT: abort to IDLE; no bus access; addr_reg unchanged.
- spi_cs_n rising while in REQ: the access is NOT aborted. Complete (or time out) normally, then enter IDLE directly if cs is still high.
- New frame starting while in REQ or DONE: the falling edge is ignored. The controller stays idle for that frame.
- bus_ack in the same cycle as the timeout terminal count: the ack wins (normal completion).
- bus_ack while not in REQ: ignored.
- Address wrap: addr_reg+1 is modulo 2^ADDR_WIDTH, so 1FFFF+1=00000.
- rx_count decreasing (spi_buffer reset) while in WAIT: treat as abort, go to IDLE.

Test Plan:
- WRITE: frame [41,12,34,5A] (cmd 01 with A16=1) -> one bus_req with we=1, addr=1_1234, wr_data=5A. Ack after 3 cycles -> cmd_done pulse; bus_req low the next cycle; addr_reg=1_1234.
- READ then READ_NEXT: frame [00,20,00] with bus_rd_data=C3 -> rd_data=C3 and one rd_valid pulse at addr 0_2000. Next frame [80] with bus_rd_data=3C -> addr 0_2001, rd_data=3C.
- WRITE_NEXT wrap: addr_reg=1_FFFF, frame [C0,77] -> write addr 0_0000, data 77; exactly one bus_req per frame even if extra bytes arrive.
- Abort: frame [40,12] (WRITE) with cs released after 2 bytes -> no bus_req. A following [80] reads addr_reg+1 based on the prior address.
- Timeout: ACK_TIMEOUT=8, bus_ack held 0 -> bus_req high for 8 cycles then low; timeout_err=1; no cmd_done. Next cs falling edge clears timeout_err.
- Async reset: assert reset_n=0 mid-REQ -> bus_req and all outputs 0 immediately (no clock edge); addr_reg=0 after release.
